l2_trace_dispatcher: RTL and testbench

- Upstream stage of the L2 cache model. Accepts trace records {command, address} over a valid/ready handshake and buffers them in a small FIFO.
- Splits each address into tag/index/offset and classifies the command.
- Dispatches one request at a time to the L2 cache core.
- ClearCache and PrintCache are ordering barriers: they issue only after all earlier requests have drained and the cache core reports idle.

---
 rtl/l2_pkg.sv | 36 +++
 rtl/l2_cmd_fifo.sv | 56 +++++
 rtl/l2_trace_dispatcher.sv | 204 ++++++++++++++++++++
 tb/tb_l2_trace_dispatcher.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// Shared definitions for the L2 trace dispatcher: command codes, FSM
// state encoding and command classification helpers.
package l2_pkg;

    localparam logic [3:0] CMD_L1_DRD  = 4'd0;
    localparam logic [3:0] CMD_L1_DWR  = 4'd1;
    localparam logic [3:0] CMD_L1_IRD  = 4'd2;
    localparam logic [3:0] CMD_SNP_INV = 4'd3;
    localparam logic [3:0] CMD_SNP_RD  = 4'd4;
    localparam logic [3:0] CMD_SNP_WR  = 4'd5;
    localparam logic [3:0] CMD_SNP_RFO = 4'd6;
    localparam logic [3:0] CMD_CLEAR   = 4'd8;
    localparam logic [3:0] CMD_PRINT   = 4'd9;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_BARRIER = 2'd2
    } disp_state_e;

    // Snoop traffic from other agents (codes 3..6).
    function automatic logic is_snoop(input logic [3:0] cmd);
        return (cmd >= CMD_SNP_INV) && (cmd <= CMD_SNP_RFO);
    endfunction

    // Ordinary requests that issue without ordering constraints (codes 0..6).
    function automatic logic is_normal(input logic [3:0] cmd);
        return cmd <= CMD_SNP_RFO;
    endfunction

    // Ordering barriers that wait for the cache core to go quiet.
    function automatic logic is_barrier(input logic [3:0] cmd);
        return (cmd == CMD_CLEAR) || (cmd == CMD_PRINT);
    endfunction

endpackage

// File: rtl/l2_cmd_fifo.sv
// Small synchronous FIFO for trace records. Pointers carry one extra wrap
// bit so full and empty are told apart without a separate counter.
module l2_cmd_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    import l2_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values; requests against full/empty are ignored.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    end

    // Pointer registers, cleared by reset so the buffer reads as empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/l2_trace_dispatcher.sv
// L2 trace dispatcher: buffers {cmd, addr} trace records, drops unknown
// commands, splits addresses into tag/index/offset and issues one request
// at a time to the cache core. ClearCache/PrintCache wait until all earlier
// requests have left and the core is idle.
// Optional macro L2_DISPATCH_STATS_EN adds saturating read/write/snoop
// counters, cleared by reset and by a ClearCache transfer.
module l2_trace_dispatcher #(
    parameter int ADDR_W     = 32,
    parameter int OFFSET_W   = 6,
    parameter int INDEX_W    = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32,
    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_cmd,
    input  logic [ADDR_W-1:0]   in_addr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          out_cmd,
    output logic [TAG_W-1:0]    out_tag,
    output logic [INDEX_W-1:0]  out_index,
    output logic [OFFSET_W-1:0] out_offset,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                out_is_snoop,
    input  logic                cache_busy,
    output logic                err_unsupported
`ifdef L2_DISPATCH_STATS_EN
    ,
    output logic [CNT_W-1:0]    stat_reads,
    output logic [CNT_W-1:0]    stat_writes,
    output logic [CNT_W-1:0]    stat_snoops
`endif
);
    import l2_pkg::*;

    localparam int REC_W = 4 + ADDR_W;

    disp_state_e       state_q, state_d;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [REC_W-1:0]  head_rec;
    logic [3:0]        head_cmd;
    logic [ADDR_W-1:0] head_addr;
    logic              load, out_fire, out_free;
    logic              out_valid_q, out_valid_d;
    logic [3:0]        out_cmd_q, out_cmd_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              err_q, err_d;

    // Nothing is accepted while reset is held, even though the FIFO is empty.
    assign in_ready  = rst_n && !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign head_cmd  = head_rec[REC_W-1 -: 4];
    assign head_addr = head_rec[ADDR_W-1:0];

    l2_cmd_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_push),
        .wr_data ({in_cmd, in_addr}),
        .rd_en   (fifo_pop),
        .rd_data (head_rec),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_fire = out_valid_q && out_ready;
    assign out_free = !out_valid_q || out_ready;

    // Dispatch FSM: decide pops, output loads and error pulses.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        load     = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (!fifo_empty) begin
                    if (is_normal(head_cmd)) begin
                        if (out_free) begin
                            fifo_pop = 1'b1;
                            load     = 1'b1;
                        end
                    end else if (is_barrier(head_cmd)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        fifo_pop = 1'b1;
                        err_d    = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Earlier requests gone and the core reports idle.
                if (!out_valid_q && !cache_busy) begin
                    state_d = ST_BARRIER;
                end
            end
            ST_BARRIER: begin
                // The barrier still sits at the head; issue it, then wait for it to leave.
                if (!out_valid_q) begin
                    fifo_pop = 1'b1;
                    load     = 1'b1;
                end else if (out_fire) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Output stage next value: load from the FIFO head or hold until taken.
    always_comb begin
        out_valid_d = out_valid_q;
        out_cmd_d   = out_cmd_q;
        out_addr_d  = out_addr_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_cmd_d   = head_cmd;
            out_addr_d  = head_addr;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // State, output stage and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            out_cmd_q   <= '0;
            out_addr_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_cmd_q   <= out_cmd_d;
            out_addr_q  <= out_addr_d;
            err_q       <= err_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_cmd         = out_cmd_q;
    assign out_addr        = out_addr_q;
    assign out_tag         = out_addr_q[ADDR_W-1:INDEX_W+OFFSET_W];
    assign out_index       = out_addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign out_offset      = out_addr_q[OFFSET_W-1:0];
    assign out_is_snoop    = is_snoop(out_cmd_q);
    assign err_unsupported = err_q;

`ifdef L2_DISPATCH_STATS_EN
    logic [CNT_W-1:0] reads_q, reads_d;
    logic [CNT_W-1:0] writes_q, writes_d;
    logic [CNT_W-1:0] snoops_q, snoops_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Counters move on an output transfer; ClearCache leaving wipes them.
    always_comb begin
        reads_d  = reads_q;
        writes_d = writes_q;
        snoops_d = snoops_q;
        if (out_fire) begin
            if (out_cmd_q == CMD_CLEAR) begin
                reads_d  = '0;
                writes_d = '0;
                snoops_d = '0;
            end else if (out_cmd_q == CMD_L1_DRD || out_cmd_q == CMD_L1_IRD) begin
                reads_d = sat_inc(reads_q);
            end else if (out_cmd_q == CMD_L1_DWR) begin
                writes_d = sat_inc(writes_q);
            end else if (is_snoop(out_cmd_q)) begin
                snoops_d = sat_inc(snoops_q);
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reads_q  <= '0;
            writes_q <= '0;
            snoops_q <= '0;
        end else begin
            reads_q  <= reads_d;
            writes_q <= writes_d;
            snoops_q <= snoops_d;
        end
    end

    assign stat_reads  = reads_q;
    assign stat_writes = writes_q;
    assign stat_snoops = snoops_q;
`endif

endmodule

// File: tb/tb_l2_trace_dispatcher.sv
// Self-checking bench for l2_trace_dispatcher. A transaction-level model
// (queue of accepted records, counters per command class) is compared
// against the DUT every cycle; directed steps pin timing and barrier rules.
module tb_l2_trace_dispatcher;

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 6;
    localparam int INDEX_W  = 14;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int CNT_W    = 3;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
    } rec_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [3:0]          in_cmd = '0;
    logic [ADDR_W-1:0]   in_addr = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [3:0]          out_cmd;
    logic [TAG_W-1:0]    out_tag;
    logic [INDEX_W-1:0]  out_index;
    logic [OFFSET_W-1:0] out_offset;
    logic [ADDR_W-1:0]   out_addr;
    logic                out_is_snoop;
    logic                cache_busy = 1'b0;
    logic                err_unsupported;
`ifdef L2_DISPATCH_STATS_EN
    logic [CNT_W-1:0]    stat_reads, stat_writes, stat_snoops;
`endif

    l2_trace_dispatcher #(
        .ADDR_W     (ADDR_W),
        .OFFSET_W   (OFFSET_W),
        .INDEX_W    (INDEX_W),
        .FIFO_DEPTH (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_cmd          (in_cmd),
        .in_addr         (in_addr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_cmd         (out_cmd),
        .out_tag         (out_tag),
        .out_index       (out_index),
        .out_offset      (out_offset),
        .out_addr        (out_addr),
        .out_is_snoop    (out_is_snoop),
        .cache_busy      (cache_busy),
        .err_unsupported (err_unsupported)
`ifdef L2_DISPATCH_STATS_EN
        ,
        .stat_reads      (stat_reads),
        .stat_writes     (stat_writes),
        .stat_snoops     (stat_snoops)
`endif
    );

    always #5 clk = ~clk;

    int   compared = 0;
    int   mismatched = 0;
    rec_t exp_q[$];
    int   exp_err = 0;
    int   err_seen = 0;
    int   err_run = 0;
    int   err_maxrun = 0;
    int   xfers = 0;
    logic [3:0]  last_cmd = '0;
    logic [31:0] last_addr = '0;
    logic        hold_prev = 1'b0;
    logic [3:0]  h_cmd = '0;
    logic [31:0] h_addr = '0;
    logic        rand_en = 1'b0;
    int m_reads = 0, m_writes = 0, m_snoops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // Per-cycle comparison against the transaction model, at the negedge.
    task automatic compare();
        rec_t e;
        logic [31:0] t;
        if (!rst_n) begin
            exp_q.delete();
            hold_prev = 1'b0;
            m_reads = 0; m_writes = 0; m_snoops = 0;
            err_run = 0;
            return;
        end
        if (hold_prev) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_cmd", {28'b0, out_cmd}, {28'b0, h_cmd});
            check("hold_addr", out_addr, h_addr);
        end
        if (err_unsupported) begin
            err_seen++;
            err_run++;
            if (err_run > err_maxrun) err_maxrun = err_run;
        end else begin
            err_run = 0;
        end
        if (out_valid) begin
            t = out_addr >> (OFFSET_W + INDEX_W);
            check("tag_field", {{(32-TAG_W){1'b0}}, out_tag}, t);
            t = (out_addr >> OFFSET_W) & 32'h3FFF;
            check("index_field", {{(32-INDEX_W){1'b0}}, out_index}, t);
            t = out_addr & 32'h3F;
            check("offset_field", {{(32-OFFSET_W){1'b0}}, out_offset}, t);
            t = (out_cmd >= 3 && out_cmd <= 6) ? 32'd1 : 32'd0;
            check("is_snoop", {31'b0, out_is_snoop}, t);
        end
`ifdef L2_DISPATCH_STATS_EN
        check("stat_reads", {29'b0, stat_reads}, m_reads);
        check("stat_writes", {29'b0, stat_writes}, m_writes);
        check("stat_snoops", {29'b0, stat_snoops}, m_snoops);
`endif
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_xfer: got cmd %0d addr 0x%0h, expected nothing", out_cmd, out_addr);
            end else begin
                e = exp_q.pop_front();
                check("xfer_cmd", {28'b0, out_cmd}, {28'b0, e.cmd});
                check("xfer_addr", out_addr, e.addr);
            end
            last_cmd = out_cmd;
            last_addr = out_addr;
            xfers++;
            if (out_cmd == 8) begin
                m_reads = 0; m_writes = 0; m_snoops = 0;
            end else if (out_cmd == 0 || out_cmd == 2) m_reads = sat(m_reads);
            else if (out_cmd == 1) m_writes = sat(m_writes);
            else if (out_cmd >= 3 && out_cmd <= 6) m_snoops = sat(m_snoops);
        end
        hold_prev = out_valid && !out_ready;
        h_cmd = out_cmd;
        h_addr = out_addr;
        if (in_valid && in_ready) begin
            if (in_cmd <= 6 || in_cmd == 8 || in_cmd == 9) begin
                e.cmd = in_cmd;
                e.addr = in_addr;
                exp_q.push_back(e);
            end else begin
                exp_err++;
            end
        end
    endtask

    // Sample this cycle at the negedge, then step past the next rising edge.
    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        if (rand_en) begin
            out_ready = ($urandom_range(0, 3) != 0);
            cache_busy = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic push(input logic [3:0] c, input logic [31:0] a);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_cmd = c;
        in_addr = a;
        while (!in_ready && n < 300) begin
            cycle();
            n++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL push_timeout: got in_ready 0 for %0d cycles, expected 1", n);
        end
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
            cycle();
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int fails_busy;
        int eb;
        logic [3:0] c;
        int r;

        // Reset values while rst_n is low.
        #2;
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_in_ready", {31'b0, in_ready}, 0);
        check("rst_err", {31'b0, err_unsupported}, 0);
        check("rst_out_cmd", {28'b0, out_cmd}, 0);
        check("rst_out_addr", out_addr, 0);
        cycle();
        cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();
        check("post_rst_in_ready", {31'b0, in_ready}, 1);

        // Two-cycle latency and field split of a single record.
        in_valid = 1'b1; in_cmd = 4'd0; in_addr = 32'h0000_1040;
        cycle();
        in_valid = 1'b0;
        check("lat_cycle1_valid", {31'b0, out_valid}, 0);
        cycle();
        check("lat_cycle2_valid", {31'b0, out_valid}, 1);
        check("lat_cmd", {28'b0, out_cmd}, 0);
        check("lat_tag", {{(32-TAG_W){1'b0}}, out_tag}, 32'h0);
        check("lat_index", {{(32-INDEX_W){1'b0}}, out_index}, 32'h041);
        check("lat_offset", {{(32-OFFSET_W){1'b0}}, out_offset}, 32'h00);
        check("lat_is_snoop", {31'b0, out_is_snoop}, 0);
        cycle();
`ifdef L2_DISPATCH_STATS_EN
        check("stat_reads_one", {29'b0, stat_reads}, 1);
`endif

        // Backpressure: output holds record 1, FIFO fills with four more.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(4'd1, 32'hA000_0000 + 32'(i * 64));
        check("full_in_ready", {31'b0, in_ready}, 0);
        check("held_first_addr", out_addr, 32'hA000_0000);
        out_ready = 1'b1;
        eb = xfers;
        for (int i = 0; i < 5; i++) cycle();
        check("back_to_back_xfers", xfers - eb, 5);
        wait_drain("bp_drain");

        // Barrier must wait for an idle core and an empty output stage.
        cache_busy = 1'b1;
        push(4'd1, 32'h1234_5678);
        push(4'd8, 32'h0);
        push(4'd4, 32'h8765_4321);
        fails_busy = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (out_valid && (out_cmd == 4'd8 || out_cmd == 4'd4)) fails_busy++;
        end
        check("barrier_held_busy", fails_busy, 0);
        check("barrier_prior_issued", {28'b0, last_cmd}, 1);
        cache_busy = 1'b0;
        wait_drain("barrier_drain");
        check("barrier_follower_last", {28'b0, last_cmd}, 4);

        // Unsupported command is dropped with a one-cycle error pulse.
        eb = err_seen;
        err_maxrun = 0;
        push(4'd7, 32'hDEAD_BEEF);
        push(4'd2, 32'h0000_0010);
        wait_drain("unsup_drain");
        for (int i = 0; i < 3; i++) cycle();
        check("unsup_pulse_count", err_seen - eb, 1);
        check("unsup_pulse_width", err_maxrun, 1);
        check("unsup_last_cmd", {28'b0, last_cmd}, 2);
        check("unsup_last_addr", last_addr, 32'h10);

        // Random stream with random backpressure and busy, across pointer wrap.
        rand_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 19);
            if (r < 14) c = 4'(r % 7);
            else if (r < 16) c = 4'(r - 6);
            else if (r == 16) c = 4'd7;
            else if (r == 17) c = 4'd11;
            else c = 4'(r % 7);
            push(c, $urandom);
            if ($urandom_range(0, 2) == 0) cycle();
        end
        rand_en = 1'b0;
        out_ready = 1'b1;
        cache_busy = 1'b0;
        wait_drain("rand_drain");
        for (int i = 0; i < 2; i++) cycle();
        check("err_total", err_seen, exp_err);

`ifdef L2_DISPATCH_STATS_EN
        push(4'd0, 32'h40);
        push(4'd5, 32'h80);
        push(4'd8, 32'h0);
        wait_drain("clear_drain");
        cycle();
        check("clear_reads", {29'b0, stat_reads}, 0);
        check("clear_writes", {29'b0, stat_writes}, 0);
        check("clear_snoops", {29'b0, stat_snoops}, 0);
`endif

        // Asynchronous reset with records queued and the output occupied.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(4'd3, 32'hC000_0000 + 32'(i));
        check("pre_rst_valid", {31'b0, out_valid}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, out_valid}, 0);
        check("async_rst_in_ready", {31'b0, in_ready}, 0);
        cycle();
        cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        eb = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (out_valid) eb++;
        end
        check("no_stale_after_rst", eb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
